// File: rtl/balance_bcd_converter_pkg.sv
// Shared constants for the balance binary-to-BCD converter: FSM encoding,
// digit width, saturation digit and the power-of-ten helper.
package balance_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] SAT_DIGIT = 4'd9;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/balance_bcd_converter_bcd_digit_adj.sv
// Single BCD digit correction cell for double dabble: add 3 when the digit is >= 5.
module bcd_digit_adj
  import balance_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] dig_i,
  output logic [DIGIT_W-1:0] dig_o
);

  assign dig_o = (dig_i >= DIGIT_W'(5)) ? dig_i + DIGIT_W'(3) : dig_i;

endmodule

// File: rtl/balance_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional leading-zero blanking enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module balance_bcd_converter
  import balance_bcd_converter_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BIN_W-1:0]          binIn,
  input  logic                      inValid,
  output logic                      inReady,
  output logic [DIGIT_W*DIGITS-1:0] bcdOut,
  output logic                      done,
  output logic                      ovf,
  output logic [DIGITS-1:0]         blankMask
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CMP_W = ((BIN_W > BCD_W) ? BIN_W : BCD_W) + 1;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(pow10(DIGITS));
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e                          state_q, state_d;
  logic [BIN_W-1:0]                shift_q, shift_d;
  logic [DIGITS-1:0][DIGIT_W-1:0]  scr_q, scr_d, scr_adj;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            ovf_flag_q, ovf_flag_d;
  logic [BCD_W-1:0]                bcd_q, bcd_d;
  logic [DIGITS-1:0]               blank_q, blank_d;
  logic                            ovf_q, done_q;
  logic                            accept, load_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.dig_i(scr_q[g]), .dig_o(scr_adj[g]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inValid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inReady  = (state_q == IDLE);
    accept   = inValid && (state_q == IDLE);
    load_out = (state_q == DONE);
  end

  always_comb begin
    shift_d    = shift_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (accept) begin
      shift_d    = binIn;
      scr_d      = '0;
      cnt_d      = CNT_W'(BIN_W);
      ovf_flag_d = (CMP_W'(binIn) >= LIMIT);
    end else if (state_q == SHIFT) begin
      // bits leaving the top digit are dropped; only reachable on overflow
      {scr_d, shift_d} = {scr_adj, shift_q} << 1;
      cnt_d            = cnt_q - CNT_W'(1);
    end
  end

  assign bcd_d = ovf_flag_q ? {DIGITS{SAT_DIGIT}} : scr_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic all_zero;
  always_comb begin
    blank_d  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero   = all_zero && (scr_q[i] == '0);
      blank_d[i] = all_zero && !ovf_flag_q;
    end
  end
`else
  assign blank_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      done_q     <= load_out;
      if (load_out) begin
        bcd_q   <= bcd_d;
        blank_q <= blank_d;
        ovf_q   <= ovf_flag_q;
      end
    end
  end

  assign bcdOut    = bcd_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign blankMask = blank_q;

endmodule
